outinf: RTL and testbench
=========================

// Module: outinf
// PURPOSE
// - Output-side stream transmitter for the convolution engine; mirrors inpinf on the output side.
// - Takes PB*2-bit results from pixel_unit, scales/saturates them to PB bits, and buffers them.
// - Drives px_out_* with valid/ready handshake, correct last_x/last_y framing and a done flag.
// - Sits between pixel_unit and the top-level px_out port.
// PARAMETERS
// - XB     10  frame width counter bits
// - YB     10  frame height counter bits
// - PB     8   output pixel bits; input result is PB*2 bits
// - KS     3   kernel size; output frame is (cfg_width-KS+1) x (cfg_height-KS+1)
// - SH     0   right shift applied to result before saturation
// - DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
// - clk            in   1       clock, rising edge
// - rst            in   1       async reset, active-low (0 = reset)
// - cfg_width      in   XB      input frame width, latched on start
// - cfg_height     in   YB      input frame height, latched on start
// - start          in   1       frame start pulse
// - pix_in         in   PB*2    unsigned result from pixel_unit
// - pix_valid      in   1       pix_in valid
// - pix_ready      out  1       outinf accepts pix_in this cycle
// - px_out_data    out  PB      output pixel
// - px_out_valid   out  1       output pixel valid
// - px_out_ready   in   1       downstream accepts
// - px_out_last_x  out  1       last pixel of an output row
// - px_out_last_y  out  1       pixel belongs to last output row
// - done           out  1       frame fully transmitted
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty, counters 0; pix_ready=0, px_out_valid=0, px_out_data=0,
//   last_x=0, last_y=0, done=0. Reset mid-frame discards FIFO contents and counters.
// - FSM IDLE -> STREAM on start. STREAM -> DONE when the final pixel handshakes out.
//   DONE -> STREAM on start. start is ignored in STREAM.
// - On start: latch ow=cfg_width-KS+1, oh=cfg_height-KS+1; clear all counters; done=0.
//   If cfg_width<KS or cfg_height<KS, the frame is empty: go directly to DONE, done=1 next cycle.
// - Input accept: pix_ready = (state==STREAM) & !fifo_full & (in_cnt < ow*oh).
//   Push on pix_valid&pix_ready. Pixels offered after ow*oh are not accepted.
// - pix_ready uses the registered full flag. A pop in the same cycle does not open a slot.
// - Scaling: r = pix_in >> SH. Data = (r > 2**PB-1) ? all-ones : r[PB-1:0]. Saturation happens before the push.
// - FIFO is show-ahead. A pixel pushed at cycle N can appear on px_out at N+1 at the earliest.
//   Push and pop in the same cycle are both legal, including when the FIFO is empty or full.
// - Output: px_out_valid = !fifo_empty. Pop on px_out_valid&px_out_ready.
//   px_out_data, last_x and last_y hold steady while valid=1 and ready=0.
// - x_cnt/y_cnt advance on every pop. x wraps at ow-1 and increments y.
//   last_x = (x_cnt==ow-1), last_y = (y_cnt==oh-1); both are gated with px_out_valid.
// - done rises the cycle after the pop with last_x&last_y. It stays high until the next start or reset.
// - ow*oh arithmetic uses XB+YB bits; no overflow.
// STRUCTURE
// - Shared package conv_pkg: outinf_state_t enum {IDLE,STREAM,DONE}, function sat_shift(PB,SH).
// - Sub-module sync_fifo (DEPTH x PB, show-ahead, full/empty flags).
//   Reuse it for any future inpinf buffering.
// - outinf holds the FSM, the frame counters and the saturation logic.
// TESTING
// - 4x4 cfg, KS=3, ready=1, 4 pixels 10,20,30,40 -> out 10,20,30,40; last_x on 2nd,4th;
//   last_y on 3rd,4th; done=1 cycle after 4th handshake.
// - DEPTH=4, px_out_ready=0 for 10 cycles, pix_valid=1 -> pix_ready drops after 4 pushes;
//   data held stable, no loss or duplication when ready returns.
// - pix_in=16'h0123 -> 8'hFF; 16'h007F -> 8'h7F; SH=4 with 16'h0FF0 -> 8'hFF, 16'h07F0 -> 8'h7F.
// - cfg_width=2 + start -> done=1 next cycle; px_out_valid never asserts; pix_ready stays 0.
// - Assert rst low after 2 of 4 outputs -> all outputs 0 immediately; a new start runs a clean frame.
// - After 4 accepted pixels a 5th pix_valid is held -> pix_ready=0; start in STREAM is ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution engine stream interfaces.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} outinf_state_t;

    // Right-shift by sh, then clamp to the largest pb-bit unsigned value.
    function automatic logic [63:0] sat_shift(input logic [63:0] v,
                                              input int unsigned pb,
                                              input int unsigned sh);
        logic [63:0] r;
        logic [63:0] mx;
        r  = v >> sh;
        mx = (64'd1 << pb) - 64'd1;
        return (r > mx) ? mx : r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on dout_o whenever not empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/outinf.sv
// Output stream transmitter: saturates pixel_unit results, buffers them and
// frames them with last_x/last_y and a done flag.
module outinf
    import conv_pkg::*;
#(
    parameter int XB    = 10,
    parameter int YB    = 10,
    parameter int PB    = 8,
    parameter int KS    = 3,
    parameter int SH    = 0,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic            start,
    input  logic [2*PB-1:0] pix_in,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic [PB-1:0]   px_out_data,
    output logic            px_out_valid,
    input  logic            px_out_ready,
    output logic            px_out_last_x,
    output logic            px_out_last_y,
    output logic            done
);
    localparam int CW = XB + YB;

    outinf_state_t state_q, state_d;
    logic [XB-1:0] ow_q, x_q;
    logic [YB-1:0] oh_q, y_q;
    logic [CW-1:0] in_cnt_q, total;
    logic [PB-1:0] sat_px, fifo_dout;
    logic          fifo_full, fifo_empty;
    logic          cfg_empty, start_ok, push, pop, at_last_x, at_last_y, final_pop;

    assign total     = CW'(ow_q) * CW'(oh_q);
    assign cfg_empty = (cfg_width < XB'(KS)) || (cfg_height < YB'(KS));
    assign start_ok  = start && (state_q != STREAM);
    assign sat_px    = PB'(sat_shift(64'(pix_in), PB, SH));
    assign push      = pix_valid & pix_ready;
    assign pop       = px_out_valid & px_out_ready;
    assign at_last_x = (x_q == ow_q - XB'(1));
    assign at_last_y = (y_q == oh_q - YB'(1));
    assign final_pop = pop & at_last_x & at_last_y;

    sync_fifo #(.W(PB), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .din_i   (sat_px),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = cfg_empty ? DONE : STREAM;
            STREAM:     if (final_pop) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Head data is undefined while empty, so the output bus is gated to zero.
    always_comb begin
        pix_ready     = (state_q == STREAM) && !fifo_full && (in_cnt_q < total);
        px_out_valid  = !fifo_empty;
        px_out_data   = px_out_valid ? fifo_dout : '0;
        px_out_last_x = px_out_valid & at_last_x;
        px_out_last_y = px_out_valid & at_last_y;
        done          = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ow_q     <= '0;
            oh_q     <= '0;
            in_cnt_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (start_ok) begin
            ow_q     <= cfg_width - XB'(KS) + XB'(1);
            oh_q     <= cfg_height - YB'(KS) + YB'(1);
            in_cnt_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            if (push) in_cnt_q <= in_cnt_q + 1'b1;
            if (pop) begin
                if (at_last_x) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_outinf.sv
// Randomised bench for outinf: a queue-based reference tracks accepted pixels,
// expected saturated values and frame position arithmetic for SH=0 and SH=4.
module tb_outinf;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  cfg_w = '0, cfg_h = '0;
    logic        start = 1'b0, pix_valid = 1'b0, px_out_ready = 1'b0;
    logic [15:0] pix_in = '0;

    logic       rdy0, v0, lx0, ly0, dn0, rdy4, v4, lx4, ly4, dn4;
    logic [7:0] d0, d4;

    always #5 clk = ~clk;

    outinf #(.SH(0)) u0 (
        .clk(clk), .rst(rst), .cfg_width(cfg_w), .cfg_height(cfg_h), .start(start),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy0),
        .px_out_data(d0), .px_out_valid(v0), .px_out_ready(px_out_ready),
        .px_out_last_x(lx0), .px_out_last_y(ly0), .done(dn0));

    outinf #(.SH(4)) u4 (
        .clk(clk), .rst(rst), .cfg_width(cfg_w), .cfg_height(cfg_h), .start(start),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy4),
        .px_out_data(d4), .px_out_valid(v4), .px_out_ready(px_out_ready),
        .px_out_last_x(lx4), .px_out_last_y(ly4), .done(dn4));

    int n_chk = 0, n_err = 0;
    int mow = 1, moh = 1, mtot = 0, min_cnt = 0, mout = 0;
    int q0[$], q4[$], stim[$];
    bit done_pend = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int sh);
        int r;
        r = v >> sh;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference monitor: pops compared before pushes since a push is never visible the same cycle.
    always @(negedge clk) begin
        if (!rst) begin
            q0.delete();
            q4.delete();
            done_pend = 0;
        end else begin
            if (done_pend) begin
                chk("done_rise", dn0, 1);
                chk("done_rise4", dn4, 1);
                done_pend = 0;
            end
            if (v0 && px_out_ready) begin
                if (q0.size() > 0) chk("data0", d0, q0.pop_front());
                else chk("underflow0", 0, 1);
                chk("last_x", lx0, (mout % mow) == mow - 1);
                chk("last_y", ly0, (mout / mow) == moh - 1);
                chk("done_low", dn0, 0);
                mout++;
                if (mout == mtot) done_pend = 1;
            end
            if (v4 && px_out_ready) begin
                if (q4.size() > 0) chk("data4", d4, q4.pop_front());
                else chk("underflow4", 0, 1);
            end
            if (pix_valid && rdy0) begin
                chk("acc_limit", min_cnt < mtot, 1);
                q0.push_back(sat(int'(pix_in), 0));
                min_cnt++;
            end
            if (pix_valid && rdy4) q4.push_back(sat(int'(pix_in), 4));
        end
    end

    task automatic new_frame(input int w, input int h);
        cfg_w   = 10'(w);
        cfg_h   = 10'(h);
        mow     = (w >= 3) ? w - 2 : 1;
        moh     = (h >= 3) ? h - 2 : 1;
        mtot    = (w >= 3 && h >= 3) ? mow * moh : 0;
        min_cnt = 0;
        mout    = 0;
        q0.delete();
        q4.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mtot > 0) chk("done_clr", dn0, 0);
    endtask

    task automatic feed();
        int k = 0;
        int guard = 0;
        while (k < stim.size() && guard < 300) begin
            pix_valid = 1'b1;
            pix_in    = 16'(stim[k]);
            @(negedge clk);
            if (rdy0) k++;
            tick();
            guard++;
        end
        pix_valid = 1'b0;
        chk("feed_timeout", k, stim.size());
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!dn0 && i < budget) begin
            tick();
            i++;
        end
        chk("done_timeout", dn0, 1);
    endtask

    initial begin
        int acc;
        logic [7:0] first;
        bit have;

        // reset state
        repeat (2) tick();
        chk("rst_ready", rdy0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_data", d0, 0);
        chk("rst_lx", lx0, 0);
        chk("rst_ly", ly0, 0);
        chk("rst_done", dn0, 0);
        rst = 1'b1;
        tick();

        // basic 4x4 frame
        px_out_ready = 1'b1;
        new_frame(4, 4);
        stim = {10, 20, 30, 40};
        feed();
        wait_done(50);
        tick();

        // saturation cases
        new_frame(4, 4);
        stim = {'h0123, 'h007F, 'h0FF0, 'h07F0};
        feed();
        wait_done(50);
        tick();

        // backpressure: FIFO fills, head holds steady
        new_frame(6, 6);
        px_out_ready = 1'b0;
        pix_valid    = 1'b1;
        acc  = 0;
        have = 0;
        first = '0;
        for (int i = 0; i < 10; i++) begin
            pix_in = 16'(100 + i * 7);
            @(negedge clk);
            if (rdy0) acc++;
            if (v0) begin
                if (!have) begin first = d0; have = 1; end
                else chk("bp_hold", d0, first);
            end
            tick();
        end
        @(negedge clk);
        chk("bp_accepts", acc, 4);
        chk("bp_ready_low", rdy0, 0);
        tick();
        px_out_ready = 1'b1;
        stim = {};
        for (int i = 0; i < 12; i++) stim.push_back(200 + i * 13);
        feed();
        // over-delivery is refused and a start mid-stream is ignored
        pix_valid = 1'b1;
        pix_in    = 16'h0055;
        @(negedge clk);
        chk("over_ready", rdy0, 0);
        tick();
        cfg_w = 10'd4;
        cfg_h = 10'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        pix_valid = 1'b0;
        chk("frame_count", mout, 16);
        tick();

        // empty frame
        new_frame(2, 5);
        @(negedge clk);
        chk("empty_done", dn0, 1);
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("empty_valid", v0, 0);
            chk("empty_ready", rdy0, 0);
        end
        tick();
        pix_valid = 1'b0;

        // reset after two of four outputs
        new_frame(4, 4);
        px_out_ready = 1'b0;
        stim = {1, 2, 3, 4};
        feed();
        px_out_ready = 1'b1;
        tick();
        tick();
        chk("mid_pops", mout, 2);
        rst = 1'b0;
        #1;
        chk("mrst_valid", v0, 0);
        chk("mrst_data", d0, 0);
        chk("mrst_lx", lx0, 0);
        chk("mrst_ly", ly0, 0);
        chk("mrst_ready", rdy0, 0);
        chk("mrst_done", dn0, 0);
        tick();
        rst = 1'b1;
        tick();
        new_frame(4, 4);
        stim = {5, 6, 7, 8};
        feed();
        wait_done(50);
        chk("clean_count", mout, 4);
        tick();

        // random frames with random valid/ready
        for (int f = 0; f < 6; f++) begin
            int guard = 0;
            new_frame(int'($urandom_range(3, 8)), int'($urandom_range(3, 7)));
            while (guard < 3000) begin
                pix_valid    = ($urandom_range(0, 3) != 0);
                pix_in       = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
                px_out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (dn0) break;
                tick();
                guard++;
            end
            pix_valid = 1'b0;
            chk("rand_done", dn0, 1);
            chk("rand_count", mout, mtot);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
